// File: rtl/rst_seq_ctrl_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding, reset-cause codes,
// default parameter values and a small counter-load helper.
package rst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ASSERT  = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_RELEASE = 3'd3,
    ST_WAIT_HI = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_SW   = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;

  localparam int DEF_NDOM        = 3;
  localparam int DEF_RST_GAP     = 4;
  localparam int DEF_ACK_TIMEOUT = 1024;

  // A zero length or gap would never let a down-counter reach its exit value.
  function automatic logic [15:0] at_least_one(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_sync2.sv
// Two-flop synchronizer bank; resets to 0 so an unsynchronized input reads as
// "domain held in reset" until it has been sampled twice.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: asserts all domain soft resets, waits for acknowledge, then
// releases the domains one at a time, RST_GAP cycles apart, and waits again.
module rst_seq_ctrl
  import rst_pkg::*;
#(
  parameter int NDOM        = DEF_NDOM,
  parameter int RST_GAP     = DEF_RST_GAP,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic            pclk,
  input  logic            prst_n,
  input  logic            test_mode,
  input  logic            sw_rst_req,
  input  logic            wdt_expire,
  input  logic [7:0]      rst_len,
  input  logic [NDOM-1:0] dom_rst_n_in,
  output logic [NDOM-1:0] dom_rst_req_n,
  output logic            busy,
  output logic [1:0]      rst_cause,
  output logic            timeout_err
);

  localparam int IDX_W = (NDOM > 1) ? $clog2(NDOM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDOM - 1);
  localparam logic [15:0] GAP_LD  = at_least_one(16'(RST_GAP));
  localparam logic [15:0] TO_LAST = (ACK_TIMEOUT <= 1)     ? 16'd0 :
                                    (ACK_TIMEOUT > 65536) ? 16'hFFFF :
                                                            16'(ACK_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      tcnt_q, tcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NDOM-1:0]  req_n_q, req_n_d;
  logic [1:0]       cause_q, cause_d;
  logic             pend_q, pend_d;
  logic             terr_q, terr_d;
  logic [NDOM-1:0]  ack_s;
  logic             leave_lo;

  sync2 #(.WIDTH(NDOM)) u_ack_sync (
    .clk_i  (pclk),
    .rst_ni (prst_n),
    .d_i    (dom_rst_n_in),
    .q_o    (ack_s)
  );

  // NOTE: every variable gets a default at the top of the block so that no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    tcnt_d   = (tcnt_q == 16'hFFFF) ? tcnt_q : tcnt_q + 16'd1;
    req_n_d  = req_n_q;
    cause_d  = cause_q;
    pend_d   = pend_q;
    terr_d   = terr_q;
    leave_lo = 1'b0;

    if (test_mode) begin
      state_d = ST_IDLE;
      req_n_d = '1;
      pend_d  = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
      tcnt_d  = '0;
    end else begin
      if (state_q != ST_IDLE && wdt_expire) pend_d = 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (sw_rst_req || wdt_expire || pend_q) begin
            state_d = ST_ASSERT;
            cause_d = (wdt_expire || pend_q) ? CAUSE_WDT : CAUSE_SW;
            cnt_d   = at_least_one({8'd0, rst_len});
            req_n_d = '0;
            pend_d  = 1'b0;
            tcnt_d  = '0;
          end
        end

        ST_ASSERT: begin
          if (cnt_q <= 16'd1) begin
            state_d = ST_WAIT_LO;
            tcnt_d  = '0;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end

        ST_WAIT_LO: begin
          if (ack_s == '0) begin
            leave_lo = 1'b1;
          end else if (tcnt_q >= TO_LAST) begin
            leave_lo = 1'b1;
            terr_d   = 1'b1;
          end
        end

        ST_RELEASE: begin
          if (cnt_q <= 16'd1) begin
            req_n_d[idx_q] = 1'b1;
            if (idx_q == LAST_IDX) begin
              state_d = ST_WAIT_HI;
              tcnt_d  = '0;
            end else begin
              idx_d = idx_q + 1'b1;
              cnt_d = GAP_LD;
            end
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end

        ST_WAIT_HI: begin
          if (&ack_s) begin
            state_d = ST_IDLE;
            tcnt_d  = '0;
          end else if (tcnt_q >= TO_LAST) begin
            state_d = ST_IDLE;
            tcnt_d  = '0;
            terr_d  = 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          req_n_d = '1;
        end
      endcase

      // Domain 0 is released on RELEASE entry; a single domain skips RELEASE.
      if (leave_lo) begin
        req_n_d[0] = 1'b1;
        tcnt_d     = '0;
        if (NDOM == 1) begin
          state_d = ST_WAIT_HI;
        end else begin
          state_d = ST_RELEASE;
          cnt_d   = GAP_LD;
          idx_d   = IDX_W'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      idx_q   <= '0;
      req_n_q <= '1;
      cause_q <= CAUSE_NONE;
      pend_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      idx_q   <= idx_d;
      req_n_q <= req_n_d;
      cause_q <= cause_d;
      pend_q  <= pend_d;
      terr_q  <= terr_d;
    end
  end

  assign dom_rst_req_n = test_mode ? '1 : req_n_q;
  assign busy          = (state_q != ST_IDLE);
  assign rst_cause     = cause_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: a two-flop domain model echoes the soft
// reset requests back as acknowledges; expected timings are hand-derived.
`timescale 1ns/1ps
module tb_rst_seq_ctrl;

  localparam int NDOM = 3;

  logic            pclk = 1'b0;
  logic            prst_n = 1'b1;
  logic            test_mode = 1'b0;
  logic            sw_rst_req = 1'b0;
  logic            wdt_expire = 1'b0;
  logic [7:0]      rst_len = 8'd3;
  logic [NDOM-1:0] dom_rst_n_in;
  logic [NDOM-1:0] dom_rst_req_n;
  logic            busy;
  logic [1:0]      rst_cause;
  logic            timeout_err;

  logic [NDOM-1:0] dom_d1, dom_d2;
  logic [NDOM-1:0] stuck_hi = '0;
  logic [NDOM-1:0] force_lo = '0;

  int errors = 0;
  int checks = 0;

  always #5 pclk = ~pclk;

  rst_seq_ctrl #(
    .NDOM        (NDOM),
    .RST_GAP     (4),
    .ACK_TIMEOUT (16)
  ) dut (
    .pclk          (pclk),
    .prst_n        (prst_n),
    .test_mode     (test_mode),
    .sw_rst_req    (sw_rst_req),
    .wdt_expire    (wdt_expire),
    .rst_len       (rst_len),
    .dom_rst_n_in  (dom_rst_n_in),
    .dom_rst_req_n (dom_rst_req_n),
    .busy          (busy),
    .rst_cause     (rst_cause),
    .timeout_err   (timeout_err)
  );

  // Each domain synchronizes its soft reset request in two cycles.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      dom_d1 <= '0;
      dom_d2 <= '0;
    end else begin
      dom_d1 <= dom_rst_req_n;
      dom_d2 <= dom_d1;
    end
  end
  assign dom_rst_n_in = (dom_d2 | stuck_hi) & ~force_lo;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic pulse_sw();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    #1 prst_n = 1'b0;
    #12;
    checks++;
    if (dom_rst_req_n !== 3'b111) begin
      errors++; $display("FAIL reset_req_n: got %b required 111", dom_rst_req_n);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b required 0", busy);
    end
    checks++;
    if (rst_cause !== 2'b00) begin
      errors++; $display("FAIL reset_cause: got %b required 00", rst_cause);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL reset_timeout_err: got %b required 0", timeout_err);
    end
    @(negedge pclk);
    prst_n = 1'b1;
    tick(10);
  endtask

  task automatic test_sw_sequence();
    logic [2:0] exp_req;
    logic       exp_busy;
    rst_len = 8'd3;
    tick(8);
    pulse_sw();
    for (int r = 1; r <= 20; r++) begin
      exp_req  = (r <= 5) ? 3'b000 : (r <= 9) ? 3'b001 : (r <= 13) ? 3'b011 : 3'b111;
      exp_busy = (r <= 18);
      checks++;
      if (dom_rst_req_n !== exp_req) begin
        errors++; $display("FAIL sw_seq_req_n r=%0d: got %b required %b", r, dom_rst_req_n, exp_req);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++; $display("FAIL sw_seq_busy r=%0d: got %b required %b", r, busy, exp_busy);
      end
      tick();
    end
    checks++;
    if (rst_cause !== 2'b01) begin
      errors++; $display("FAIL sw_seq_cause: got %b required 01", rst_cause);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL sw_seq_timeout_err: got %b required 0", timeout_err);
    end
  endtask

  task automatic test_simultaneous();
    int busy_cycles = 0;
    rst_len = 8'd2;
    tick(8);
    sw_rst_req = 1'b1;
    wdt_expire = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    wdt_expire = 1'b0;
    checks++;
    if (dom_rst_req_n !== 3'b000 || busy !== 1'b1) begin
      errors++; $display("FAIL simul_start: req_n=%b busy=%b required 000/1", dom_rst_req_n, busy);
    end
    checks++;
    if (rst_cause !== 2'b10) begin
      errors++; $display("FAIL simul_cause: got %b required 10", rst_cause);
    end
    wait_idle("simul_done");
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy !== 1'b0) busy_cycles++;
    end
    checks++;
    if (busy_cycles != 0) begin
      errors++; $display("FAIL simul_single_seq: busy for %0d cycles after idle, required 0", busy_cycles);
    end
  endtask

  task automatic test_wdt_during_wait_hi();
    rst_len = 8'd3;
    tick(8);
    pulse_sw();
    tick(14);
    checks++;
    if (busy !== 1'b1 || dom_rst_req_n !== 3'b111) begin
      errors++; $display("FAIL wdt_hi_in_wait_hi: busy=%b req_n=%b required 1/111", busy, dom_rst_req_n);
    end
    wdt_expire = 1'b1;
    tick();
    wdt_expire = 1'b0;
    tick(3);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL wdt_hi_idle_cycle: busy=%b required 0", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || dom_rst_req_n !== 3'b000) begin
      errors++; $display("FAIL wdt_hi_restart: busy=%b req_n=%b required 1/000", busy, dom_rst_req_n);
    end
    checks++;
    if (rst_cause !== 2'b10) begin
      errors++; $display("FAIL wdt_hi_cause: got %b required 10", rst_cause);
    end
    wait_idle("wdt_hi_done");
  endtask

  task automatic test_rst_len_zero();
    rst_len  = 8'd0;
    force_lo = '1;
    tick(8);
    pulse_sw();
    checks++;
    if (dom_rst_req_n !== 3'b000 || busy !== 1'b1) begin
      errors++; $display("FAIL len0_assert: req_n=%b busy=%b required 000/1", dom_rst_req_n, busy);
    end
    tick();
    checks++;
    if (dom_rst_req_n !== 3'b000) begin
      errors++; $display("FAIL len0_wait_lo: req_n=%b required 000", dom_rst_req_n);
    end
    tick();
    checks++;
    if (dom_rst_req_n !== 3'b001) begin
      errors++; $display("FAIL len0_release: req_n=%b required 001", dom_rst_req_n);
    end
    force_lo = '0;
    wait_idle("len0_done");
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL len0_timeout_err: got %b required 0", timeout_err);
    end
  endtask

  task automatic test_timeout();
    rst_len  = 8'd3;
    stuck_hi = 3'b010;
    tick(8);
    pulse_sw();
    tick(18);
    checks++;
    if (dom_rst_req_n !== 3'b000 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL to_last_wait: req_n=%b terr=%b required 000/0", dom_rst_req_n, timeout_err);
    end
    tick();
    checks++;
    if (dom_rst_req_n !== 3'b001 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_exit: req_n=%b terr=%b required 001/1", dom_rst_req_n, timeout_err);
    end
    stuck_hi = '0;
    wait_idle("to_done");
    tick(8);
    pulse_sw();
    wait_idle("to_second_done");
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_sticky: got %b required 1", timeout_err);
    end
  endtask

  task automatic test_test_mode();
    int busy_cycles = 0;
    rst_len = 8'd5;
    tick(8);
    pulse_sw();
    tick();
    test_mode = 1'b1;
    #1;
    checks++;
    if (dom_rst_req_n !== 3'b111) begin
      errors++; $display("FAIL tm_same_cycle_req_n: got %b required 111", dom_rst_req_n);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL tm_next_busy: got %b required 0", busy);
    end
    sw_rst_req = 1'b1;
    wdt_expire = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    wdt_expire = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0 || dom_rst_req_n !== 3'b111) busy_cycles++;
      tick();
    end
    test_mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy !== 1'b0) busy_cycles++;
    end
    checks++;
    if (busy_cycles != 0) begin
      errors++; $display("FAIL tm_requests_ignored: %0d active cycles, required 0", busy_cycles);
    end
    checks++;
    if (rst_cause !== 2'b01) begin
      errors++; $display("FAIL tm_cause_held: got %b required 01", rst_cause);
    end
  endtask

  task automatic test_prst_mid_release();
    int busy_cycles = 0;
    rst_len = 8'd3;
    tick(8);
    pulse_sw();
    tick(7);
    checks++;
    if (dom_rst_req_n !== 3'b001) begin
      errors++; $display("FAIL prst_pre_release: req_n=%b required 001", dom_rst_req_n);
    end
    prst_n = 1'b0;
    #1;
    checks++;
    if (dom_rst_req_n !== 3'b111 || busy !== 1'b0) begin
      errors++; $display("FAIL prst_outputs: req_n=%b busy=%b required 111/0", dom_rst_req_n, busy);
    end
    checks++;
    if (rst_cause !== 2'b00 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL prst_status: cause=%b terr=%b required 00/0", rst_cause, timeout_err);
    end
    tick(2);
    prst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy !== 1'b0 || dom_rst_req_n !== 3'b111) busy_cycles++;
    end
    checks++;
    if (busy_cycles != 0) begin
      errors++; $display("FAIL prst_no_resume: %0d active cycles, required 0", busy_cycles);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_sw_sequence();
    test_simultaneous();
    test_wdt_during_wait_hi();
    test_rst_len_zero();
    test_timeout();
    test_test_mode();
    test_prst_mid_release();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter NDOM, default 3: number of reset domains; bit 0 = sdram, 1 = sys, 2 = sys_2x.
REQ-002 Parameter RST_GAP, default 4: pclk cycles between successive domain releases.
REQ-003 Parameter ACK_TIMEOUT, default 1024: pclk cycles allowed per acknowledge wait.
REQ-004 pclk  input  1  clock; all state is in the pclk domain.
REQ-005 prst_n  input  1  reset, asynchronous, active-low.
REQ-006 test_mode  input  1  1 = sequencer bypassed.
REQ-007 sw_rst_req  input  1  software reset request, single-cycle pulse.
REQ-008 wdt_expire  input  1  watchdog reset request, single-cycle pulse.
REQ-009 rst_len  input  8  assertion length in pclk cycles; 0 is treated as 1.
REQ-010 dom_rst_n_in  input  NDOM  per-domain synchronized reset, fed back as acknowledge; asynchronous to pclk.
REQ-011 dom_rst_req_n  output  NDOM  per-domain soft reset request, active-low.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 rst_cause  output  2  cause of last sequence: 00 none, 01 software, 10 watchdog.
REQ-014 timeout_err  output  1  sticky; set on any acknowledge timeout.

Function
REQ-015 Each dom_rst_n_in bit passes through a 2-flop synchronizer before use (ack_s).
REQ-016 FSM states: IDLE, ASSERT, WAIT_LO, RELEASE, WAIT_HI.
REQ-017 IDLE: on sw_rst_req, wdt_expire or wdt_pend, go to ASSERT next cycle; load rst_cause; load counter with max(rst_len,1).
REQ-018 Simultaneous sw_rst_req and wdt_expire: watchdog wins, rst_cause = 10.
REQ-019 In the cycle after the request, dom_rst_req_n is all 0 (1-cycle latency).
REQ-020 ASSERT: decrement counter each cycle; at 1, go to WAIT_LO; dom_rst_req_n held all 0.
REQ-021 WAIT_LO: go to RELEASE when ack_s is all 0, or after ACK_TIMEOUT cycles; a timeout sets timeout_err.
REQ-022 RELEASE: deassert dom_rst_req_n[0] on entry, then bits 1..NDOM-1 in order, RST_GAP cycles apart; go to WAIT_HI in the cycle the last bit deasserts.
REQ-023 WAIT_HI: go to IDLE when ack_s is all 1, or after ACK_TIMEOUT cycles; a timeout sets timeout_err.
REQ-024 sw_rst_req outside IDLE is ignored.
REQ-025 wdt_expire outside IDLE sets wdt_pend; wdt_pend clears when its sequence starts.
REQ-026 timeout_err clears only on prst_n.
REQ-027 Timeout counter: 16-bit, saturating; reloaded on every state entry.
REQ-028 test_mode=1 forces IDLE at the next edge, dom_rst_req_n all 1 combinationally, busy 0, requests ignored, wdt_pend cleared; rst_cause and timeout_err are held.

Reset
REQ-029 prst_n low asynchronously sets: FSM = IDLE, dom_rst_req_n all 1, busy 0, rst_cause 00, timeout_err 0, wdt_pend 0, counters 0.
REQ-030 Synchronizer flops reset to 0, so the domains read as in reset.
REQ-031 prst_n asserted mid-sequence aborts the sequence; no request is retained.

Structure
REQ-032 Shared package rst_pkg holds the state enum, cause codes (CAUSE_NONE, CAUSE_SW, CAUSE_WDT) and default parameter constants.
REQ-033 Sub-module sync2 (parameterized width, 2-flop, async active-low reset to 0) is instantiated for dom_rst_n_in.

Verification
REQ-034 Software sequence: rst_len=3, RST_GAP=4, sw pulse at cycle 10, domains ack after 2 synchronizer cycles.
- req_n = 000 at cycles 11-13.
- Bits release at 4-cycle intervals: bit 0, then bit 1 (+4), then bit 2 (+8).
- busy drops after all acks return 1; rst_cause = 01; timeout_err = 0.
REQ-035 Simultaneous sw and wdt pulse -> rst_cause = 10; exactly one sequence runs.
REQ-036 wdt pulse during WAIT_HI -> second sequence starts 1 cycle after IDLE is reached; rst_cause = 10.
REQ-037 dom_rst_n_in[1] stuck at 1, ACK_TIMEOUT=16 -> WAIT_LO exits after 16 cycles; timeout_err = 1 and stays 1 until prst_n.
REQ-038 rst_len=0 -> exactly one ASSERT cycle.
REQ-039 test_mode=1 mid-ASSERT -> req_n = 111 in the same cycle, busy = 0 the next cycle, sw pulses ignored.
REQ-040 prst_n pulse mid-RELEASE -> all outputs return to reset values; no sequence resumes afterwards.
